// File: rtl/vector_alu_wb.sv
// 4-lane x 32-bit vector ALU with serialized one-element-per-cycle register-file writeback.
// Optional feature: define VEC_ALU_MASK_EN to add the in_mask lane write-enable port.
module vector_alu_wb #(
   parameter int LANES = 4,
   parameter int W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_op,
   input  logic [3:0]         in_dst_row,
   input  logic [LANES*W-1:0] in_a,
   input  logic [LANES*W-1:0] in_b,
`ifdef VEC_ALU_MASK_EN
   input  logic [LANES-1:0]   in_mask,
`endif
   output logic               wr_en,
   output logic [3:0]         wr_row,
   output logic [1:0]         wr_col,
   output logic [W-1:0]       wr_data,
   output logic               done,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t                    state_r, nxt_state_s;
   logic [1:0]                lane_r, nxt_lane_s;
   logic [2:0]                op_r;
   logic [3:0]                row_r;
   logic [LANES-1:0][W-1:0]   a_r, b_r, res_r, lane_res_s;
   logic [LANES-1:0]          mask_r, cap_mask_s;
   logic                      accept_s;
   logic                      nxt_wr_en_s, nxt_done_s;
   logic [3:0]                nxt_wr_row_s;
   logic [1:0]                nxt_wr_col_s;
   logic [W-1:0]              nxt_wr_data_s;

   function automatic logic [W-1:0] alu_lane(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         3'b000:  r = a + b;
         3'b001:  r = a - b;
         3'b010:  r = a & b;
         3'b011:  r = a | b;
         3'b100:  r = a ^ b;
         3'b101:  r = a << b[4:0];
         3'b110:  r = a >> b[4:0];
         3'b111:  r = a * b;
         default: r = '0;
      endcase
      return r;
   endfunction

`ifdef VEC_ALU_MASK_EN
   assign cap_mask_s = in_mask;
`else
   assign cap_mask_s = {LANES{1'b1}};
`endif

   // Per-lane results from the captured operands; lanes never interact.
   always_comb begin
      lane_res_s = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_res_s[i] = alu_lane(op_r, a_r[i], b_r[i]);
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      nxt_state_s   = state_r;
      nxt_lane_s    = lane_r;
      accept_s      = 1'b0;
      nxt_wr_en_s   = 1'b0;
      nxt_done_s    = 1'b0;
      nxt_wr_row_s  = wr_row;
      nxt_wr_col_s  = wr_col;
      nxt_wr_data_s = wr_data;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               accept_s    = 1'b1;
               nxt_state_s = EXEC;
            end else begin
               nxt_state_s = IDLE;
            end
         end
         EXEC: begin
            // Lane 0 is driven straight from the fresh results so slot 0 lands one cycle after EXEC.
            nxt_state_s   = WRITE;
            nxt_lane_s    = 2'd0;
            nxt_wr_en_s   = mask_r[0];
            nxt_wr_row_s  = row_r;
            nxt_wr_col_s  = 2'd0;
            nxt_wr_data_s = lane_res_s[0];
         end
         WRITE: begin
            if (lane_r == 2'd3) begin
               nxt_state_s = IDLE;
            end else begin
               nxt_lane_s    = lane_r + 2'd1;
               nxt_wr_en_s   = mask_r[nxt_lane_s];
               nxt_wr_row_s  = row_r;
               nxt_wr_col_s  = nxt_lane_s;
               nxt_wr_data_s = res_r[nxt_lane_s];
               nxt_done_s    = (nxt_lane_s == 2'd3);
            end
         end
         default: begin
            nxt_state_s = IDLE;
         end
      endcase
   end

   // State and lane counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         lane_r  <= 2'd0;
      end else begin
         state_r <= nxt_state_s;
         lane_r  <= nxt_lane_s;
      end
   end

   // Request capture at accept and result capture in EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r   <= 3'd0;
         row_r  <= 4'd0;
         a_r    <= '0;
         b_r    <= '0;
         mask_r <= '0;
         res_r  <= '0;
      end else begin
         if (accept_s) begin
            op_r   <= in_op;
            row_r  <= in_dst_row;
            a_r    <= in_a;
            b_r    <= in_b;
            mask_r <= cap_mask_s;
         end
         if (state_r == EXEC) begin
            res_r <= lane_res_s;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready <= 1'b1;
         busy     <= 1'b0;
         wr_en    <= 1'b0;
         done     <= 1'b0;
         wr_row   <= 4'd0;
         wr_col   <= 2'd0;
         wr_data  <= '0;
      end else begin
         in_ready <= (nxt_state_s == IDLE);
         busy     <= (nxt_state_s != IDLE);
         wr_en    <= nxt_wr_en_s;
         done     <= nxt_done_s;
         wr_row   <= nxt_wr_row_s;
         wr_col   <= nxt_wr_col_s;
         wr_data  <= nxt_wr_data_s;
      end
   end

endmodule

// File: tb/tb_vector_alu_wb.sv
// Directed self-checking bench for vector_alu_wb; build with VEC_ALU_MASK_EN to cover lane masking.
module tb_vector_alu_wb;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_op;
   logic [3:0]   in_dst_row;
   logic [127:0] in_a, in_b;
`ifdef VEC_ALU_MASK_EN
   logic [3:0]   in_mask;
`endif
   logic         wr_en;
   logic [3:0]   wr_row;
   logic [1:0]   wr_col;
   logic [31:0]  wr_data;
   logic         done;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vector_alu_wb dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_dst_row (in_dst_row),
      .in_a       (in_a),
      .in_b       (in_b),
`ifdef VEC_ALU_MASK_EN
      .in_mask    (in_mask),
`endif
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_data    (wr_data),
      .done       (done),
      .busy       (busy)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called in the cycle after the accept edge; walks EXEC, four write slots and the return to IDLE.
   task automatic check_op(input string tag, input logic [3:0] row,
                           input logic [127:0] exp, input logic [3:0] mask);
      logic [31:0] e;
      chk({tag, " exec busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " exec in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, " exec wr_en"}, {31'd0, wr_en}, 32'd0);
      for (int l = 0; l < 4; l++) begin
         step();
         e = exp[32*l +: 32];
         chk($sformatf("%s lane%0d wr_en", tag, l), {31'd0, wr_en}, {31'd0, mask[l]});
         chk($sformatf("%s lane%0d wr_row", tag, l), {28'd0, wr_row}, {28'd0, row});
         chk($sformatf("%s lane%0d wr_col", tag, l), {30'd0, wr_col}, l);
         chk($sformatf("%s lane%0d wr_data", tag, l), wr_data, e);
         chk($sformatf("%s lane%0d done", tag, l), {31'd0, done}, (l == 3) ? 32'd1 : 32'd0);
      end
      step();
      chk({tag, " end in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, " end busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " end wr_en"}, {31'd0, wr_en}, 32'd0);
      chk({tag, " end done"}, {31'd0, done}, 32'd0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [3:0] row,
                        input logic [127:0] a, input logic [127:0] b);
      in_valid   = 1'b1;
      in_op      = op;
      in_dst_row = row;
      in_a       = a;
      in_b       = b;
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_op      = 3'd0;
      in_dst_row = 4'd0;
      in_a       = '0;
      in_b       = '0;
`ifdef VEC_ALU_MASK_EN
      in_mask    = 4'hF;
`endif
      step();
      step();
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst wr_row", {28'd0, wr_row}, 32'd0);
      chk("rst wr_col", {30'd0, wr_col}, 32'd0);
      chk("rst wr_data", wr_data, 32'd0);
      reset = 1'b0;
      step();

      // ADD with wrap; inputs scrambled right after accept must not matter.
      issue(3'b000, 4'd5, {32'd7, 32'd10, 32'hFFFFFFFF, 32'd1}, {32'd0, 32'd20, 32'd1, 32'd2});
      step();
      in_valid = 1'b0;
      in_a = {4{32'hDEADBEEF}};
      in_b = {4{32'h12345678}};
      in_op = 3'b111;
      in_dst_row = 4'd9;
      check_op("add", 4'd5, {32'd7, 32'd30, 32'd0, 32'd3}, 4'hF);

      issue(3'b001, 4'd1, {32'd0, 32'd5, 32'd100, 32'h80000000}, {32'd1, 32'd3, 32'd100, 32'd1});
      step();
      in_valid = 1'b0;
      check_op("sub", 4'd1, {32'hFFFFFFFF, 32'd2, 32'd0, 32'h7FFFFFFF}, 4'hF);

      issue(3'b101, 4'd2, {32'd1, 32'd1, 32'h80000001, 32'hF}, {32'd33, 32'd0, 32'd31, 32'd4});
      step();
      in_valid = 1'b0;
      check_op("sll", 4'd2, {32'd2, 32'd1, 32'h80000000, 32'hF0}, 4'hF);

      issue(3'b111, 4'd3, {32'h10000, 32'd3, 32'hFFFFFFFF, 32'h12345}, {32'h10000, 32'd5, 32'hFFFFFFFF, 32'd0});
      step();
      in_valid = 1'b0;
      check_op("mul", 4'd3, {32'd0, 32'd15, 32'd1, 32'd0}, 4'hF);

      issue(3'b011, 4'd7, {32'hF0, 32'd0, 32'h80000000, 32'd1}, {32'h0F, 32'd0, 32'd1, 32'h10});
      step();
      in_valid = 1'b0;
      check_op("or", 4'd7, {32'hFF, 32'd0, 32'h80000001, 32'h11}, 4'hF);

      issue(3'b110, 4'd8, {32'h80000000, 32'hFFFFFFFF, 32'h100, 32'h12345678}, {32'd31, 32'd32, 32'd4, 32'h24});
      step();
      in_valid = 1'b0;
      check_op("srl", 4'd8, {32'd1, 32'hFFFFFFFF, 32'h10, 32'h01234567}, 4'hF);

      // Handshake: in_valid held high across two back-to-back requests.
      issue(3'b010, 4'd4, {32'hF0F0F0F0, 32'hFFFFFFFF, 32'd0, 32'h12345678},
                          {32'hFF00FF00, 32'd0, 32'hFFFFFFFF, 32'h0F0F0F0F});
      step();
      issue(3'b100, 4'd6, {32'hF0F0F0F0, 32'hFFFFFFFF, 32'd0, 32'h12345678},
                          {32'hFF00FF00, 32'd0, 32'hFFFFFFFF, 32'h0F0F0F0F});
      check_op("hs_and", 4'd4, {32'hF000F000, 32'd0, 32'd0, 32'h02040608}, 4'hF);
      step();
      in_valid = 1'b0;
      check_op("hs_xor", 4'd6, {32'h0FF00FF0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1D3B5977}, 4'hF);

      // Reset during the lane-1 slot.
      issue(3'b000, 4'd5, {32'd7, 32'd10, 32'hFFFFFFFF, 32'd1}, {32'd0, 32'd20, 32'd1, 32'd2});
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("mid lane1 wr_en", {31'd0, wr_en}, 32'd1);
      chk("mid lane1 wr_col", {30'd0, wr_col}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid async wr_en", {31'd0, wr_en}, 32'd0);
      chk("mid async busy", {31'd0, busy}, 32'd0);
      chk("mid async in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid async wr_data", wr_data, 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("mid post %0d wr_en", i), {31'd0, wr_en}, 32'd0);
         chk($sformatf("mid post %0d in_ready", i), {31'd0, in_ready}, 32'd1);
      end

      issue(3'b001, 4'd9, {32'd0, 32'd5, 32'd100, 32'h80000000}, {32'd1, 32'd3, 32'd100, 32'd1});
      step();
      in_valid = 1'b0;
      check_op("recover", 4'd9, {32'hFFFFFFFF, 32'd2, 32'd0, 32'h7FFFFFFF}, 4'hF);

`ifdef VEC_ALU_MASK_EN
      issue(3'b000, 4'd5, {32'd7, 32'd10, 32'hFFFFFFFF, 32'd1}, {32'd0, 32'd20, 32'd1, 32'd2});
      in_mask = 4'b0101;
      step();
      in_valid = 1'b0;
      in_mask = 4'b1010;
      check_op("mask0101", 4'd5, {32'd7, 32'd30, 32'd0, 32'd3}, 4'b0101);

      issue(3'b000, 4'd2, {32'd7, 32'd10, 32'hFFFFFFFF, 32'd1}, {32'd0, 32'd20, 32'd1, 32'd2});
      in_mask = 4'b0000;
      step();
      in_valid = 1'b0;
      check_op("mask0000", 4'd2, {32'd7, 32'd30, 32'd0, 32'd3}, 4'b0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vector_alu_wb.md
# vector_alu_wb

Lane-wise 4×32-bit vector execute and writeback stage that sits directly downstream of the vector register file. It takes the two 4-lane read vectors for an instruction, applies one of eight element-wise operations, and writes the 4-lane result back into the register file one element per cycle. The register file accepts one element write per cycle, which is why this block serializes the writeback.

## Interface
Parameters:
- `LANES`, 4: vector lanes; fixed at 4, other values unsupported.
- `W`, 32: element width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `in_op`  in  3  opcode.
- `in_dst_row`  in  4  destination register row.
- `in_a`  in  128  operand A; lane i = bits [32i+31:32i].
- `in_b`  in  128  operand B; same lane packing.
- `in_mask`  in  4  lane write enables; present only with `VEC_ALU_MASK_EN`.
- `wr_en`  out  1  register-file element write enable.
- `wr_row`  out  4  register-file row address.
- `wr_col`  out  2  register-file column (lane) address.
- `wr_data`  out  32  element write data.
- `done`  out  1  one-cycle pulse on the final lane slot.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE → EXEC → WRITE (4 slots) → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_op`, `in_dst_row`, `in_a`, `in_b` (and `in_mask`) and go to EXEC.
  - Later changes on the inputs have no effect.
- EXEC: compute and register all four lane results, set lane counter to 0, go to WRITE.
- WRITE:
  - Drive `wr_row`=captured row, `wr_col`=lane counter, `wr_data`=result[lane], `wr_en`=1 (masked per Configuration).
  - Increment the counter each cycle. After lane 3, return to IDLE.
- `in_valid` outside IDLE is ignored. The requester must hold its request until it is accepted.
- Opcodes, evaluated per lane, all modulo 2^32, with no flags:
  - 000 ADD: a+b.
  - 001 SUB: a−b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: a << b[4:0].
  - 110 SRL: a >> b[4:0], logical.
  - 111 MUL: low 32 bits of a×b, unsigned.
- Lanes are independent, with no carry between lanes.
- Reset values: state IDLE, `in_ready`=1, `busy`=0, `wr_en`=0, `done`=0, `wr_row`=0, `wr_col`=0, `wr_data`=0, lane counter 0.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - The in-flight operation is discarded, and lanes not yet written stay unwritten.

## Timing
- All outputs are registered. The accept edge is edge 0.
- Cycle after edge 0: EXEC, `busy`=1, `in_ready`=0, `wr_en`=0.
- Cycles after edges 1–4: WRITE lanes 0,1,2,3, one per cycle, with `wr_en` high.
- `done`=1 only in the lane-3 cycle.
- Cycle after edge 5: IDLE, `in_ready`=1.
- Throughput: one operation per 6 cycles. Latency from accept to last write: 5 cycles.
- The register file samples `wr_*` on the following rising edge. A read of the destination row returns the new full vector from the cycle after edge 5.

## Configuration
- Macro: `VEC_ALU_MASK_EN`.
- Defined:
  - The `in_mask` port exists and is captured at accept.
  - In a lane's slot, `wr_en` = mask[lane]; `wr_row`, `wr_col` and `wr_data` are still driven.
  - Slot count and timing are unchanged. `done` still pulses in the lane-3 cycle, even when mask=0000.
- Undefined: no `in_mask` port; all four lanes are written.

## Test plan
- Reset check: assert `reset` for 2 cycles → `in_ready`=1, `busy`=0, `wr_en`=0, `done`=0, all `wr_*`=0.
- ADD with wrap:
  - Stimulus: row 5, a lanes {1, 0xFFFFFFFF, 10, 7}, b lanes {2, 1, 20, 0}.
  - Response: writes (5,0,3), (5,1,0), (5,2,30), (5,3,7) in cycles 1–4; `done` in cycle 4; `in_ready` in cycle 5.
- SUB/SLL/MUL:
  - SUB: 0−1 → 0xFFFFFFFF.
  - SLL: 1<<33 uses shift 1 → 2.
  - MUL: 0x10000×0x10000 → 0.
- Handshake: hold `in_valid` continuously with two differing ops → exactly two 6-cycle operations, no overlap, second captured at its accept edge.
- Reset mid-write: assert `reset` during the lane-1 slot → `wr_en` low at once; no lane 2/3 writes; after release, `in_ready`=1.
- With `VEC_ALU_MASK_EN` and mask 0101 → `wr_en` high only in the lane-0 and lane-2 slots; `done` still in cycle 4.
